bp_be_late_wb_arbiter: RTL and testbench
========================================

BP_BE_LATE_WB_ARBITER -- requirements
Module: bp_be_late_wb_arbiter

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, processor configuration selecting vaddr_width_p.
REQ-002 SHALL have parameter num_req_p, default 3, number of late-writeback requesters: 0=dcache miss load, 1=integer divider, 2=FP divider.
REQ-003 SHALL have parameter starve_cycles_p, default 8, stall cycles before force is raised.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 reset_n_i  input  1  asynchronous active-low reset.
REQ-007 req_pkt_i  input  num_req_p*wb_pkt_width_lp  per-requester writeback packets, requester i in slice i.
REQ-008 req_v_i  input  num_req_p  per-requester valid.
REQ-009 req_yumi_o  output  num_req_p  one-hot grant; packet consumed this cycle.
REQ-010 late_wb_pkt_o  output  wb_pkt_width_lp  buffered packet to scheduler/detector.
REQ-011 late_wb_v_o  output  1  buffer occupied.
REQ-012 late_wb_force_o  output  1  scheduler must take writeback port this cycle.
REQ-013 late_wb_src_o  output  $clog2(num_req_p)  requester index of buffered packet.
REQ-014 late_wb_yumi_i  input  1  scheduler consumed buffered packet.

Function
REQ-015 SHALL hold a one-entry output buffer (pkt, src, valid) driving late_wb_*_o directly from flops.
REQ-016 Buffer SHALL be "free" when late_wb_v_o=0 or late_wb_yumi_i=1 in the same cycle.
REQ-017 When free and any req_v_i set, SHALL assert exactly one req_yumi_o bit combinationally; otherwise req_yumi_o=0.
REQ-018 Winner SHALL be first valid requester in round-robin order starting at rr_ptr+1 modulo num_req_p.
REQ-019 rr_ptr SHALL update to the winner index only on a grant; unchanged otherwise.
REQ-020 Granted packet SHALL appear on late_wb_pkt_o with late_wb_v_o=1 on the next cycle (1-cycle latency).
REQ-021 Yumi and new grant in same cycle SHALL replace the buffer back-to-back, sustaining 1 packet/cycle.
REQ-022 Yumi without a grant SHALL clear late_wb_v_o the next cycle.
REQ-023 late_wb_yumi_i while late_wb_v_o=0 is illegal; block SHALL ignore it (no state change).
REQ-024 Wait counter SHALL reset to 0 on buffer load and increment each cycle late_wb_v_o=1 and late_wb_yumi_i=0, saturating at starve_cycles_p.
REQ-025 late_wb_force_o SHALL equal late_wb_v_o AND (wait counter == starve_cycles_p).
REQ-026 Requesters SHALL hold req_pkt_i/req_v_i stable until granted; block does not buffer ungranted requests.
REQ-027 With single valid requester, SHALL grant it regardless of rr_ptr.

Reset
REQ-028 While reset_n_i=0: late_wb_v_o=0, late_wb_force_o=0, req_yumi_o=0, rr_ptr=num_req_p-1, wait counter=0, late_wb_src_o=0, late_wb_pkt_o=0.
REQ-029 Reset assertion mid-transfer SHALL drop the buffered packet immediately (asynchronous); no grant in first cycle after deassertion unless req_v_i set.

Structure
REQ-030 wb packet type SHALL be bp_be_wb_pkt_s from `declare_bp_be_internal_if_structs; width via `bp_be_wb_pkt_width.
REQ-031 Requester index enum (e_late_wb_dcache, e_late_wb_idiv, e_late_wb_fdiv) SHALL live in bp_be_pkg.
REQ-032 Round-robin selection SHALL be a single sub-module instance, bsg_arb_round_robin.

Verification
REQ-033 Reset release, all req_v_i=0 -> late_wb_v_o=0, req_yumi_o=000 for 10 cycles.
REQ-034 req_v_i=111 held, late_wb_yumi_i=1 every cycle -> grants 001,010,100,001 cyclic; late_wb_v_o=1 continuously from cycle 2.
REQ-035 Single grant on req 1, late_wb_yumi_i=0 for 10 cycles -> late_wb_force_o rises cycle 8 after load, stays 1; req_yumi_o=0 throughout.
REQ-036 Buffer full, late_wb_yumi_i=1 with req 2 valid same cycle -> req_yumi_o=100 that cycle; next cycle late_wb_src_o=2, wait counter 0, force 0.
REQ-037 reset_n_i pulsed low mid-cycle with buffer full -> late_wb_v_o=0 before next clock edge; rr_ptr=2, first grant after release to req 0.
REQ-038 late_wb_yumi_i=1 with late_wb_v_o=0 and no requests -> no state change, outputs remain reset values.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Back-end shared types: processor configuration, writeback packet layout
// and the late-writeback requester indices.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_sv48_cfg    = 2'd1
    } bp_params_e;

    // Virtual address width implied by a processor configuration.
    function automatic int unsigned bp_vaddr_width(bp_params_e cfg);
        return (cfg == e_bp_sv48_cfg) ? 48 : 39;
    endfunction

    // Requester slots of the late writeback arbiter.
    typedef enum logic [1:0] {
        e_late_wb_dcache = 2'd0,
        e_late_wb_idiv   = 2'd1,
        e_late_wb_fdiv   = 2'd2
    } bp_be_late_wb_src_e;

    // Register-file writeback packet.
    typedef struct packed {
        logic        ird_w_v;
        logic        frd_w_v;
        logic        fflags_w_v;
        logic [4:0]  rd_addr;
        logic [63:0] rd_data;
        logic [4:0]  fflags;
    } bp_be_wb_pkt_s;

    localparam int unsigned wb_pkt_width_lp = $bits(bp_be_wb_pkt_s);

endpackage

// File: rtl/bp_be_late_wb_arbiter_if.sv
// Late writeback bundle: requester side (packets in, yumi out) and the
// scheduler side (buffered packet out, yumi in).
interface bp_be_late_wb_arbiter_if #(
    parameter int num_req_p = 3
);
    import bp_be_pkg::*;

    localparam int src_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    bp_be_wb_pkt_s [num_req_p-1:0] req_pkt_i;
    logic [num_req_p-1:0]          req_v_i;
    logic [num_req_p-1:0]          req_yumi_o;
    bp_be_wb_pkt_s                 late_wb_pkt_o;
    logic                          late_wb_v_o;
    logic                          late_wb_force_o;
    logic [src_width_lp-1:0]       late_wb_src_o;
    logic                          late_wb_yumi_i;

    // Arbiter side.
    modport slave (
        input  req_pkt_i, req_v_i, late_wb_yumi_i,
        output req_yumi_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o, late_wb_src_o
    );

    // Requesters plus scheduler side.
    modport master (
        output req_pkt_i, req_v_i, late_wb_yumi_i,
        input  req_yumi_o, late_wb_pkt_o, late_wb_v_o, late_wb_force_o, late_wb_src_o
    );

endinterface

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin picker: first set request at or after last_i+1,
// wrapping modulo width_p. The pointer itself lives in the caller.
module bsg_arb_round_robin #(
    parameter  int width_p      = 3,
    localparam int idx_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]      reqs_i,
    input  logic [idx_width_lp-1:0] last_i,
    output logic [width_p-1:0]      grants_o,
    output logic [idx_width_lp-1:0] grant_idx_o,
    output logic                    v_o
);

    logic [idx_width_lp-1:0] cand;

    // Scan candidates in priority order; the first valid one wins.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path infers a latch.
        grants_o    = '0;
        grant_idx_o = '0;
        v_o         = 1'b0;
        cand        = '0;
        for (int off = 1; off <= width_p; off++) begin
            cand = idx_width_lp'((32'(last_i) + off) % width_p);
            if (!v_o && reqs_i[cand]) begin
                v_o            = 1'b1;
                grants_o[cand] = 1'b1;
                grant_idx_o    = cand;
            end
        end
    end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Late writeback arbiter: round-robin over the long-latency requesters into
// a one-entry buffer that feeds the scheduler, with a starvation force flag.
module bp_be_late_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter int         num_req_p       = 3,
    parameter int         starve_cycles_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_be_late_wb_arbiter_if.slave  wb_if
);

    localparam int src_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int wait_width_lp = (starve_cycles_p > 0) ? $clog2(starve_cycles_p + 1) : 1;
    localparam logic [wait_width_lp-1:0] starve_lp = wait_width_lp'(starve_cycles_p);

    bp_be_wb_pkt_s            pkt_q, pkt_d;
    logic [src_width_lp-1:0]  src_q, src_d;
    logic                     v_q, v_d;
    logic [wait_width_lp-1:0] wait_q, wait_d;
    logic [src_width_lp-1:0]  rr_ptr_q, rr_ptr_d;

    logic [num_req_p-1:0]     rr_grants;
    logic [src_width_lp-1:0]  rr_idx;
    logic                     rr_v;
    logic                     buf_free;
    logic                     grant_v;

    bsg_arb_round_robin #(.width_p(num_req_p)) u_rr (
        .reqs_i     (wb_if.req_v_i),
        .last_i     (rr_ptr_q),
        .grants_o   (rr_grants),
        .grant_idx_o(rr_idx),
        .v_o        (rr_v)
    );

    // The buffer can accept a packet when empty or being drained this cycle;
    // no grant is issued while reset is asserted.
    assign buf_free         = !v_q || wb_if.late_wb_yumi_i;
    assign grant_v          = buf_free && rr_v && reset_n_i;
    assign wb_if.req_yumi_o = {num_req_p{grant_v}} & rr_grants;

    assign wb_if.late_wb_pkt_o   = pkt_q;
    assign wb_if.late_wb_src_o   = src_q;
    assign wb_if.late_wb_v_o     = v_q;
    assign wb_if.late_wb_force_o = v_q && (wait_q == starve_lp);

    // Buffer load/drain, starvation counter and round-robin pointer update.
    // A yumi against an empty buffer falls through every branch untouched.
    always_comb begin
        pkt_d    = pkt_q;
        src_d    = src_q;
        v_d      = v_q;
        wait_d   = wait_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_v) begin
            pkt_d    = wb_if.req_pkt_i[rr_idx];
            src_d    = rr_idx;
            v_d      = 1'b1;
            wait_d   = '0;
            rr_ptr_d = rr_idx;
        end else if (v_q && wb_if.late_wb_yumi_i) begin
            v_d    = 1'b0;
            wait_d = '0;
        end else if (v_q && (wait_q != starve_lp)) begin
            wait_d = wait_q + wait_width_lp'(1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: the single-entry packet buffer is reset too, so late_wb_pkt_o reads zero out of reset.
            pkt_q    <= '0;
            src_q    <= '0;
            v_q      <= 1'b0;
            wait_q   <= '0;
            rr_ptr_q <= src_width_lp'(num_req_p - 1);
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pkt_q    <= pkt_d;
            src_q    <= src_d;
            v_q      <= v_d;
            wait_q   <= wait_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Self-checking bench for bp_be_late_wb_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_bp_be_late_wb_arbiter;
    import bp_be_pkg::*;

    localparam int n_lp      = 3;
    localparam int starve_lp = 8;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    always #5 clk_i = ~clk_i;

    bp_be_late_wb_arbiter_if #(.num_req_p(n_lp)) wb_if ();

    bp_be_late_wb_arbiter #(
        .bp_params_p    (e_bp_default_cfg),
        .num_req_p      (n_lp),
        .starve_cycles_p(starve_lp)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .wb_if    (wb_if)
    );

    // Stimulus state owned by the bench.
    logic [n_lp-1:0] req_v;
    bp_be_wb_pkt_s   req_pkt [n_lp];
    logic            yumi;

    // Behavioural model: buffer as a queue of at most one packet.
    bp_be_wb_pkt_s m_buf [$];
    int            m_src;
    int            m_rr;
    int            m_wait;
    int            e_grant;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bp_be_wb_pkt_s rand_pkt();
        bp_be_wb_pkt_s p;
        p.ird_w_v    = 1'($urandom());
        p.frd_w_v    = 1'($urandom());
        p.fflags_w_v = 1'($urandom());
        p.rd_addr    = 5'($urandom());
        p.rd_data    = {$urandom(), $urandom()};
        p.fflags     = 5'($urandom());
        return p;
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_src   = 0;
        m_rr    = n_lp - 1;
        m_wait  = 0;
        e_grant = -1;
    endtask

    task automatic drive();
        for (int i = 0; i < n_lp; i++) begin
            wb_if.req_v_i[i]   = req_v[i];
            wb_if.req_pkt_i[i] = req_pkt[i];
        end
        wb_if.late_wb_yumi_i = yumi;
    endtask

    // Apply inputs, then compare every DUT output with the model.
    task automatic sample();
        logic [n_lp-1:0] exp_yumi;
        bit              exp_v;
        bit              free;
        drive();
        #1;
        exp_v    = (m_buf.size() != 0);
        free     = !exp_v || yumi;
        exp_yumi = '0;
        e_grant  = -1;
        if (free && reset_n_i) begin
            for (int k = 1; k <= n_lp; k++) begin
                if (e_grant < 0 && req_v[(m_rr + k) % n_lp]) e_grant = (m_rr + k) % n_lp;
            end
        end
        if (e_grant >= 0) exp_yumi[e_grant] = 1'b1;
        check("req_yumi", 128'(wb_if.req_yumi_o), 128'(exp_yumi));
        check("late_wb_v", 128'(wb_if.late_wb_v_o), 128'(exp_v));
        check("late_wb_force", 128'(wb_if.late_wb_force_o), 128'(exp_v && (m_wait == starve_lp)));
        if (exp_v) begin
            check("late_wb_src", 128'(wb_if.late_wb_src_o), 128'(m_src));
            check("late_wb_pkt", 128'(wb_if.late_wb_pkt_o), 128'(m_buf[0]));
        end
    endtask

    // Cross one rising edge, updating the model from the pre-edge inputs.
    task automatic advance();
        @(posedge clk_i);
        if (e_grant >= 0) begin
            m_buf.delete();
            m_buf.push_back(req_pkt[e_grant]);
            m_src  = e_grant;
            m_wait = 0;
            m_rr   = e_grant;
        end else if (m_buf.size() != 0 && yumi) begin
            m_buf.delete();
            m_wait = 0;
        end else if (m_buf.size() != 0 && m_wait < starve_lp) begin
            m_wait++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [n_lp-1:0] seq_exp [4];
        int              accept_pct;
        seq_exp[0] = 3'b001;
        seq_exp[1] = 3'b010;
        seq_exp[2] = 3'b100;
        seq_exp[3] = 3'b001;

        req_v = '0;
        yumi  = 1'b0;
        for (int i = 0; i < n_lp; i++) req_pkt[i] = rand_pkt();
        drive();
        model_reset();

        // Reset state, with requests pending: no grant while in reset.
        @(negedge clk_i);
        req_v = 3'b111;
        sample();
        check("rst_v", 128'(wb_if.late_wb_v_o), 128'(0));
        check("rst_yumi", 128'(wb_if.req_yumi_o), 128'(0));
        check("rst_force", 128'(wb_if.late_wb_force_o), 128'(0));
        check("rst_src", 128'(wb_if.late_wb_src_o), 128'(0));
        check("rst_pkt", 128'(wb_if.late_wb_pkt_o), 128'(0));
        @(negedge clk_i);

        // Idle after release: nothing granted, buffer stays empty.
        reset_n_i = 1'b1;
        req_v     = '0;
        for (int c = 0; c < 10; c++) begin
            sample();
            check("idle_v", 128'(wb_if.late_wb_v_o), 128'(0));
            check("idle_yumi", 128'(wb_if.req_yumi_o), 128'(0));
            advance();
        end

        // All requesters held valid, scheduler drains every cycle.
        req_v = 3'b111;
        yumi  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("rr_seq", 128'(wb_if.req_yumi_o), 128'(seq_exp[k]));
            if (k >= 1) check("rr_v_cont", 128'(wb_if.late_wb_v_o), 128'(1));
            advance();
        end
        req_v = '0;
        sample();
        advance();

        // Single load from requester 1, then a long stall.
        req_v = 3'b010;
        yumi  = 1'b0;
        sample();
        check("single_grant", 128'(wb_if.req_yumi_o), 128'(3'b010));
        advance();
        req_v = '0;
        for (int k = 0; k < 10; k++) begin
            sample();
            check("starve_force", 128'(wb_if.late_wb_force_o), 128'(k >= starve_lp));
            check("starve_yumi", 128'(wb_if.req_yumi_o), 128'(0));
            advance();
        end

        // Back-to-back replace: drain and grant requester 2 in one cycle.
        req_v = 3'b100;
        yumi  = 1'b1;
        sample();
        check("b2b_grant", 128'(wb_if.req_yumi_o), 128'(3'b100));
        advance();
        req_v = '0;
        yumi  = 1'b0;
        sample();
        check("b2b_src", 128'(wb_if.late_wb_src_o), 128'(2));
        check("b2b_force", 128'(wb_if.late_wb_force_o), 128'(0));
        check("b2b_v", 128'(wb_if.late_wb_v_o), 128'(1));

        // Asynchronous reset between edges with the buffer full.
        #1;
        reset_n_i = 1'b0;
        #1;
        check("async_v", 128'(wb_if.late_wb_v_o), 128'(0));
        check("async_force", 128'(wb_if.late_wb_force_o), 128'(0));
        check("async_pkt", 128'(wb_if.late_wb_pkt_o), 128'(0));
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        req_v     = 3'b111;
        sample();
        check("post_rst_grant", 128'(wb_if.req_yumi_o), 128'(3'b001));
        advance();

        // Yumi against an empty buffer with no requests is ignored.
        reset_n_i = 1'b0;
        req_v     = '0;
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        yumi      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("bad_yumi_v", 128'(wb_if.late_wb_v_o), 128'(0));
            check("bad_yumi_src", 128'(wb_if.late_wb_src_o), 128'(0));
            check("bad_yumi_force", 128'(wb_if.late_wb_force_o), 128'(0));
            advance();
        end

        // Randomized traffic with varying scheduler acceptance rate.
        yumi       = 1'b0;
        accept_pct = 90;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ((c / 250) % 4)
                    0:       accept_pct = 90;
                    1:       accept_pct = 50;
                    2:       accept_pct = 10;
                    default: accept_pct = 0;
                endcase
            end
            for (int i = 0; i < n_lp; i++) begin
                if (!req_v[i] && $urandom_range(1) == 1) begin
                    req_v[i]   = 1'b1;
                    req_pkt[i] = rand_pkt();
                end
            end
            if (m_buf.size() != 0) yumi = ($urandom_range(99) < accept_pct);
            else                   yumi = ($urandom_range(9) == 0);
            sample();
            advance();
            if (e_grant >= 0) req_v[e_grant] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
